lcd_byte_writer: RTL and testbench

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

---
 rtl/lcd_byte_writer_pkg.sv | 49 ++++
 rtl/lcd_byte_writer.sv | 121 ++++++++++++
 tb/tb_lcd_byte_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the HD44780 byte writer:
// state encoding, default timings and clear/home codes.
package lcd_byte_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ENABLE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_WAIT   = 3'd4
   } state_e;

   localparam int unsigned T_SETUP_DEF = 1;
   localparam int unsigned T_EN_DEF    = 1;
   localparam int unsigned T_HOLD_DEF  = 1;
   localparam int unsigned T_SHORT_DEF = 40;
   localparam int unsigned T_LONG_DEF  = 1640;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   // Clear/home commands need the long execution wait
   function automatic logic is_long_cmd(
      input logic       rs,
      input logic [7:0] data
   );
      return !rs && (data == CMD_CLEAR ||
                     data == CMD_HOME  ||
                     data == CMD_HOME_ALT);
   endfunction

   function automatic int unsigned max5(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c,
      input int unsigned d,
      input int unsigned e
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// HD44780 byte writer: setup / E pulse / hold / execution
// wait, all timed in externally supplied ticks.
module lcd_byte_writer
   import lcd_byte_writer_pkg::*;
#(
   parameter int unsigned T_SETUP = T_SETUP_DEF,
   parameter int unsigned T_EN    = T_EN_DEF,
   parameter int unsigned T_HOLD  = T_HOLD_DEF,
   parameter int unsigned T_SHORT = T_SHORT_DEF,
   parameter int unsigned T_LONG  = T_LONG_DEF
) (
   input  logic       clki,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   localparam int unsigned T_MAX =
      max5(T_SETUP, T_EN, T_HOLD, T_SHORT, T_LONG);
   // Counter only reaches T-1, so T_MAX values suffice
   localparam int unsigned CW =
      (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t LIM_SETUP = cnt_t'(T_SETUP - 1);
   localparam cnt_t LIM_EN    = cnt_t'(T_EN - 1);
   localparam cnt_t LIM_HOLD  = cnt_t'(T_HOLD - 1);
   localparam cnt_t LIM_SHORT = cnt_t'(T_SHORT - 1);
   localparam cnt_t LIM_LONG  = cnt_t'(T_LONG - 1);

   state_e     state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic       rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic       e_q, e_d;
   cnt_t       lim;
   logic       adv;

   always_comb begin
      lim = LIM_SETUP;
      case (state_q)
         ST_SETUP:  lim = LIM_SETUP;
         ST_ENABLE: lim = LIM_EN;
         ST_HOLD:   lim = LIM_HOLD;
         ST_WAIT:   lim = is_long_cmd(rs_q, data_q) ?
                          LIM_LONG : LIM_SHORT;
         default:   lim = LIM_SETUP;
      endcase
   end

   assign adv = tick && (cnt_q == lim);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               rs_d    = req_rs;
               data_d  = req_data;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP, ST_ENABLE, ST_HOLD, ST_WAIT: begin
            if (tick) begin
               cnt_d = adv ? '0 : cnt_q + cnt_t'(1);
            end
            if (adv) begin
               case (state_q)
                  ST_SETUP:  state_d = ST_ENABLE;
                  ST_ENABLE: state_d = ST_HOLD;
                  ST_HOLD:   state_d = ST_WAIT;
                  default:   state_d = ST_IDLE;
               endcase
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // E is registered off the next state so it never glitches
      e_d = (state_d == ST_ENABLE);
   end

   always_ff @(posedge clki or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         e_q     <= e_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = ~req_ready;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_e     = e_q;
   assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: tick-count reference model,
// vector table, hand-built corner sequences, random traffic.
module tb_lcd_byte_writer;

   localparam int TS  = 1;
   localparam int TE  = 1;
   localparam int TH  = 1;
   localparam int TSH = 40;
   localparam int TL  = 1640;

   logic       clki;
   logic       reset_n;
   logic       tick;
   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;
   logic       busy;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data;

   lcd_byte_writer #(
      .T_SETUP(TS),
      .T_EN   (TE),
      .T_HOLD (TH),
      .T_SHORT(TSH),
      .T_LONG (TL)
   ) dut (
      .clki     (clki),
      .reset_n  (reset_n),
      .tick     (tick),
      .req_valid(req_valid),
      .req_rs   (req_rs),
      .req_data (req_data),
      .req_ready(req_ready),
      .busy     (busy),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data)
   );

   initial begin
      clki = 1'b0;
      forever #5 clki = ~clki;
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string nm,
                        input int act,
                        input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                    nm, act, exp, $time);
   endtask

   // Tick source: periodic, gated, or manually driven
   int tick_div    = 50;
   bit tick_en     = 1'b1;
   bit tick_man    = 1'b0;
   bit tick_man_val = 1'b0;
   int tcnt        = 0;

   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clki);
         if (tick_man) tick = tick_man_val;
         else if (!tick_en) begin
            tick = 1'b0;
            tcnt = 0;
         end else begin
            tcnt++;
            if (tcnt >= tick_div) begin
               tcnt = 0;
               tick = 1'b1;
            end else tick = 1'b0;
         end
      end
   end

   // Reference model: a write is busy for a fixed number of
   // counted ticks; E is high during the T_EN ticks after setup.
   function automatic int wait_len(input bit rs,
                                   input logic [7:0] d);
      return (!rs && d >= 8'd1 && d <= 8'd3) ? TL : TSH;
   endfunction

   bit         m_busy;
   bit         m_rs;
   logic [7:0] m_data;
   int         m_el;
   int         m_total;
   bit         exp_e;

   always @(posedge clki or negedge reset_n) begin
      if (!reset_n) begin
         m_busy  <= 1'b0;
         m_rs    <= 1'b0;
         m_data  <= 8'h00;
         m_el    <= 0;
         m_total <= 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  <= 1'b1;
            m_rs    <= req_rs;
            m_data  <= req_data;
            m_el    <= 0;
            m_total <= TS + TE + TH + wait_len(req_rs, req_data);
         end
      end else if (tick) begin
         m_el <= m_el + 1;
         if (m_el + 1 == m_total) m_busy <= 1'b0;
      end
   end

   assign exp_e = m_busy && (m_el >= TS) && (m_el < TS + TE);

   bit chk_en = 1'b0;

   always @(negedge clki) begin
      if (chk_en)
         check("cycle_outputs",
               int'({req_ready, busy, lcd_e, lcd_rw,
                     lcd_rs, lcd_data}),
               int'({!m_busy, m_busy, exp_e, 1'b0,
                     m_rs, m_data}));
   end

   int e_rises = 0;
   bit e_prev  = 1'b0;

   always @(negedge clki) begin
      e_prev <= lcd_e;
      if (lcd_e && !e_prev) e_rises <= e_rises + 1;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clki);
         #1;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 30000) begin
         cyc(1);
         n++;
      end
      check("wait_ready", int'(req_ready), 1);
   endtask

   task automatic wait_e(input bit val);
      int n = 0;
      while (lcd_e != val && n < 10000) begin
         cyc(1);
         n++;
      end
      check("wait_e", int'(lcd_e), int'(val));
   endtask

   task automatic issue(input bit rs, input logic [7:0] d);
      wait_ready();
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
      cyc(1);
      req_valid = 1'b0;
      req_rs    = 1'($urandom);
      req_data  = 8'($urandom);
   endtask

   // Called just after the acceptance edge
   task automatic measure(output int nt, output int eclk);
      bit prev;
      nt   = 0;
      eclk = 0;
      prev = busy;
      for (int i = 0; i < 20000; i++) begin
         cyc(1);
         if (prev && tick) nt++;
         if (lcd_e) eclk++;
         prev = busy;
         if (!busy) break;
      end
   endtask

   typedef struct {
      bit         rs;
      logic [7:0] data;
      int         div;
      int         exp_ticks;
      int         exp_eclk;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int nt, eclk, r0;

      vecs[0] = '{1'b1, 8'h41, 50, 43,   50};
      vecs[1] = '{1'b0, 8'h01, 2,  1643, 2};
      vecs[2] = '{1'b1, 8'h01, 3,  43,   3};
      vecs[3] = '{1'b0, 8'h00, 3,  43,   3};
      vecs[4] = '{1'b0, 8'h02, 1,  1643, 1};
      vecs[5] = '{1'b0, 8'h03, 1,  1643, 1};
      vecs[6] = '{1'b0, 8'h04, 4,  43,   4};
      vecs[7] = '{1'b1, 8'h02, 2,  43,   2};

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_rs    = 1'b0;
      req_data  = 8'h00;
      cyc(3);
      chk_en = 1'b1;
      check("rst_ready", int'(req_ready), 1);
      check("rst_busy",  int'(busy), 0);
      check("rst_e",     int'(lcd_e), 0);
      check("rst_rs",    int'(lcd_rs), 0);
      check("rst_rw",    int'(lcd_rw), 0);
      check("rst_data",  int'(lcd_data), 0);
      reset_n = 1'b1;
      cyc(2);

      foreach (vecs[i]) begin
         tick_div = vecs[i].div;
         issue(vecs[i].rs, vecs[i].data);
         check("vec_data", int'(lcd_data), int'(vecs[i].data));
         check("vec_rs",   int'(lcd_rs),   int'(vecs[i].rs));
         measure(nt, eclk);
         check("vec_ticks", nt, vecs[i].exp_ticks);
         check("vec_e_clks", eclk, vecs[i].exp_eclk);
         check("vec_ready", int'(req_ready), 1);
      end

      // Back-to-back with request held through busy
      tick_div = 2;
      wait_ready();
      r0 = e_rises;
      req_valid = 1'b1;
      req_rs    = 1'b0;
      req_data  = 8'h38;
      cyc(1);
      check("b2b_first_data", int'(lcd_data), 8'h38);
      req_data = 8'h0C;
      wait_ready();
      check("b2b_hold_data", int'(lcd_data), 8'h38);
      cyc(1);
      check("b2b_no_gap", int'(busy), 1);
      check("b2b_second_data", int'(lcd_data), 8'h0C);
      req_valid = 1'b0;
      measure(nt, eclk);
      check("b2b_ticks", nt, 43);
      cyc(2);
      check("b2b_e_pulses", e_rises - r0, 2);

      // Tick gated off during HOLD
      tick_div = 2;
      issue(1'b1, 8'h55);
      wait_e(1'b1);
      wait_e(1'b0);
      tick_en = 1'b0;
      for (int i = 0; i < 200; i++) begin
         req_data = 8'($urandom);
         req_rs   = 1'($urandom);
         cyc(1);
      end
      check("gate_busy", int'(busy), 1);
      check("gate_e", int'(lcd_e), 0);
      check("gate_data", int'(lcd_data), 8'h55);
      check("gate_rs", int'(lcd_rs), 1);
      tick_en = 1'b1;
      measure(nt, eclk);
      check("gate_ticks", nt, 41);

      // Reset in the middle of ENABLE
      tick_div = 3;
      issue(1'b0, 8'h80);
      wait_e(1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_e", int'(lcd_e), 0);
      check("mid_rst_data", int'(lcd_data), 0);
      check("mid_rst_ready", int'(req_ready), 1);
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h30;
      cyc(1);
      check("rst_no_accept", int'(busy), 0);
      reset_n = 1'b1;
      cyc(1);
      check("post_rst_accept", int'(busy), 1);
      check("post_rst_data", int'(lcd_data), 8'h30);
      req_valid = 1'b0;
      measure(nt, eclk);
      check("post_rst_ticks", nt, 43);

      // Tick coincident with acceptance is not counted
      wait_ready();
      tick_man     = 1'b1;
      tick_man_val = 1'b0;
      cyc(2);
      req_valid    = 1'b1;
      req_rs       = 1'b1;
      req_data     = 8'h7E;
      tick_man_val = 1'b1;
      cyc(1);
      check("acc_tick_busy", int'(busy), 1);
      req_valid    = 1'b0;
      tick_man_val = 1'b0;
      cyc(3);
      check("acc_tick_e_low", int'(lcd_e), 0);
      tick_man_val = 1'b1;
      cyc(1);
      check("acc_tick_e_high", int'(lcd_e), 1);
      tick_man_val = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 6000; i++) begin
         tick_man_val = 1'($urandom);
         req_valid    = ($urandom_range(0, 2) == 0);
         req_rs       = 1'($urandom);
         if ($urandom_range(0, 3) == 0)
            req_data = 8'($urandom_range(0, 3));
         else
            req_data = 8'($urandom);
         cyc(1);
      end
      req_valid = 1'b0;
      tick_man  = 1'b0;
      tick_en   = 1'b1;
      tick_div  = 1;
      wait_ready();
      cyc(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
